// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
package riscv_pkg;

  localparam int unsigned OP_W      = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned ALUCTL_W  = 3;
  localparam int unsigned ALUOP_W   = 2;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype;

  // Opcodes
  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;

  // Extend-unit select
  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  // ALU source A / B selects
  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  // Result mux select
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEM    = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

  // Internal ALU op class
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU decoder: maps the per-state op class and funct fields to an ALU operation.
module aludec
  import riscv_pkg::*;
(
  input  logic [ALUOP_W-1:0]  aluop,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7b5,
  input  logic                op5,
  output logic [ALUCTL_W-1:0] alucontrol
);

  // Only register-register ops with funct7b5 set subtract; addi never does.
  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7b5,
  input  logic                zero,
  output logic [SEL_W-1:0]    immsrc,
  output logic [SEL_W-1:0]    alusrca,
  output logic [SEL_W-1:0]    alusrcb,
  output logic [SEL_W-1:0]    resultsrc,
  output logic                adrsrc,
  output logic                irwrite,
  output logic                pcwrite,
  output logic                regwrite,
  output logic                memwrite,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal
);

  statetype           state, next_state;
  logic [ALUOP_W-1:0] aluop;
  logic               pcupdate;
  logic               branch;
  logic               irwrite_s;
  logic               regwrite_s;
  logic               memwrite_s;

  // State register; reset lands in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Next-state and per-state control decode
  always_comb begin
    next_state = state;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    resultsrc  = RES_ALUOUT;
    adrsrc     = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
    unique case (state)
      FETCH: begin
        adrsrc     = 1'b0;
        irwrite_s  = 1'b1;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_FOUR;
        resultsrc  = RES_ALU;
        pcupdate   = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_IALU:      next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default: begin
            next_state = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        resultsrc  = RES_MEM;
        regwrite_s = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
        next_state = FETCH;
      end
      EXECUTER: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        resultsrc  = RES_ALUOUT;
        regwrite_s = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        alusrca    = SRCA_OLDPC;
        alusrcb    = SRCB_FOUR;
        resultsrc  = RES_ALUOUT;
        pcupdate   = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        alusrca    = SRCA_RS1;
        alusrcb    = SRCB_RS2;
        aluop      = ALUOP_SUB;
        resultsrc  = RES_ALUOUT;
        branch     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  // Extend-unit select follows the opcode in every state
  always_comb begin
    immsrc = IMM_I;
    unique case (op)
      OP_SW:   immsrc = IMM_S;
      OP_BEQ:  immsrc = IMM_B;
      OP_JAL:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  // Write enables are masked by reset so an abort cannot leak a write
  assign irwrite  = irwrite_s & rst_n;
  assign pcwrite  = (pcupdate | (branch & zero)) & rst_n;
  assign regwrite = regwrite_s & rst_n;
  assign memwrite = memwrite_s & rst_n;

  aludec u_aludec (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

endmodule
